// File: rtl/all_gates_2x1_mux_mux2.sv
// rtl/all_gates_2x1_mux_mux2.sv - combinational 2:1 multiplexer primitive
module mux2 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/all_gates_2x1_mux.sv
// rtl/all_gates_2x1_mux.sv - seven two-input gate functions built only from mux2, registered
module all_gates_2x1_mux (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    output logic y_and,
    output logic y_or,
    output logic y_not,
    output logic y_nand,
    output logic y_nor,
    output logic y_xor,
    output logic y_xnor
);

    logic w_nb;
    logic w_and;
    logic w_or;
    logic w_not;
    logic w_nand;
    logic w_nor;
    logic w_xor;
    logic w_xnor;

    logic r_and;
    logic r_or;
    logic r_not;
    logic r_nand;
    logic r_nor;
    logic r_xor;
    logic r_xnor;

    // Inverted b is shared by the NAND/NOR/XOR/XNOR data inputs.
    mux2 u_nb   (.d0(1'b1), .d1(1'b0), .sel(b), .y(w_nb));

    mux2 u_and  (.d0(1'b0), .d1(b),    .sel(a), .y(w_and));
    mux2 u_or   (.d0(b),    .d1(1'b1), .sel(a), .y(w_or));
    mux2 u_not  (.d0(1'b1), .d1(1'b0), .sel(a), .y(w_not));
    mux2 u_nand (.d0(1'b1), .d1(w_nb), .sel(a), .y(w_nand));
    mux2 u_nor  (.d0(w_nb), .d1(1'b0), .sel(a), .y(w_nor));
    mux2 u_xor  (.d0(b),    .d1(w_nb), .sel(a), .y(w_xor));
    mux2 u_xnor (.d0(w_nb), .d1(b),    .sel(a), .y(w_xnor));

    // Reset clears every output, including the ones that read 1 for a=b=0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_and  <= 1'b0;
            r_or   <= 1'b0;
            r_not  <= 1'b0;
            r_nand <= 1'b0;
            r_nor  <= 1'b0;
            r_xor  <= 1'b0;
            r_xnor <= 1'b0;
        end else begin
            r_and  <= w_and;
            r_or   <= w_or;
            r_not  <= w_not;
            r_nand <= w_nand;
            r_nor  <= w_nor;
            r_xor  <= w_xor;
            r_xnor <= w_xnor;
        end
    end

    assign y_and  = r_and;
    assign y_or   = r_or;
    assign y_not  = r_not;
    assign y_nand = r_nand;
    assign y_nor  = r_nor;
    assign y_xor  = r_xor;
    assign y_xnor = r_xnor;

endmodule

// File: tb/tb_all_gates_2x1_mux.sv
// tb/tb_all_gates_2x1_mux.sv - self-checking bench for all_gates_2x1_mux
module tb_all_gates_2x1_mux;

    logic clk;
    logic rst_n;
    logic a;
    logic b;
    logic y_and;
    logic y_or;
    logic y_not;
    logic y_nand;
    logic y_nor;
    logic y_xor;
    logic y_xnor;

    int checks;
    int failures;

    typedef struct {
        logic       a;
        logic       b;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[4];

    all_gates_2x1_mux dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .y_and  (y_and),
        .y_or   (y_or),
        .y_not  (y_not),
        .y_nand (y_nand),
        .y_nor  (y_nor),
        .y_xor  (y_xor),
        .y_xnor (y_xnor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Order: and, or, not, nand, nor, xor, xnor.
    function automatic logic [6:0] outs();
        return {y_and, y_or, y_not, y_nand, y_nor, y_xor, y_xnor};
    endfunction

    function automatic logic [6:0] ref_row(input logic ra, input logic rb);
        int s;
        int p;
        s = int'(ra) + int'(rb);
        p = int'(ra) * int'(rb);
        return {p == 1, s >= 1, ra == 1'b0, p == 0, s == 0, s == 1, s != 1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check7(input string name, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end
    endtask

    initial begin
        logic [6:0] exp_prev;
        checks   = 0;
        failures = 0;

        vecs[0] = '{a: 1'b0, b: 1'b0, exp: 7'b0011101};
        vecs[1] = '{a: 1'b0, b: 1'b1, exp: 7'b0111010};
        vecs[2] = '{a: 1'b1, b: 1'b0, exp: 7'b0101010};
        vecs[3] = '{a: 1'b1, b: 1'b1, exp: 7'b1100001};

        rst_n = 1'b0;
        a     = 1'b1;
        b     = 1'b1;
        step();
        step();
        check7("reset_state", outs(), 7'b0000000);

        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = vecs[i].a;
            b = vecs[i].b;
            step();
            check7($sformatf("sweep_%0d%0d", vecs[i].a, vecs[i].b), outs(), vecs[i].exp);
            check7($sformatf("model_%0d%0d", vecs[i].a, vecs[i].b), outs(), ref_row(vecs[i].a, vecs[i].b));
        end

        a = 1'b0;
        b = 1'b0;
        step();
        check1("latency_before", y_not, 1'b1);
        #2;
        a = 1'b1;
        #1;
        check1("latency_midcycle", y_not, 1'b1);
        step();
        check1("latency_after", y_not, 1'b0);

        a = 1'b0;
        b = 1'b0;
        step();
        check7("midreset_pre", outs(), 7'b0011101);
        rst_n = 1'b0;
        step();
        check7("midreset_cleared", outs(), 7'b0000000);
        rst_n = 1'b1;
        step();
        check7("midreset_release", outs(), 7'b0011101);

        exp_prev = ref_row(a, b);
        for (int i = 0; i < 64; i++) begin
            logic ra;
            logic rb;
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            a = ra;
            b = rb;
            step();
            exp_prev = ref_row(ra, rb);
            check7($sformatf("rand_%0d", i), outs(), exp_prev);
            check1($sformatf("inv_nand_%0d", i), y_nand, ~y_and);
            check1($sformatf("inv_nor_%0d", i), y_nor, ~y_or);
            check1($sformatf("inv_xnor_%0d", i), y_xnor, ~y_xor);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/all_gates_2x1_mux.md
# all_gates_2x1_mux

Logic-gate library block that produces the seven basic two-input gate functions of inputs `a` and `b` (NOT on `a`). Every function is built only from 2:1 multiplexer instances, with no behavioural gate operators, to show that the 2:1 mux is functionally complete. It serves as a reference and teaching primitive in the gate-equivalence set, next to the 4:1 and 8:1 mux variants. All outputs are registered on a single clock.

## Interface
- Parameters: none.
- `clk`  input  1  rising-edge clock; all state updates on its rising edge.
- `rst_n`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `a`  input  1  operand A; it is also the operand of the NOT function.
- `b`  input  1  operand B.
- `y_and`  output  1  registered a AND b.
- `y_or`  output  1  registered a OR b.
- `y_not`  output  1  registered NOT a.
- `y_nand`  output  1  registered NOT (a AND b).
- `y_nor`  output  1  registered NOT (a OR b).
- `y_xor`  output  1  registered a XOR b.
- `y_xnor`  output  1  registered NOT (a XOR b).
- Port order is fixed: `clk`, `rst_n`, `a`, `b`, `y_and`, `y_or`, `y_not`, `y_nand`, `y_nor`, `y_xor`, `y_xnor`.

## Operation
- The combinational core consists only of `mux2` instances with `y = sel ? d1 : d0`. Constants 0 and 1 may drive the data inputs.
- Required mux mapping:
  - `nb`: sel=b, d0=1, d1=0, giving the internal NOT b.
  - AND: sel=a, d0=0, d1=b.
  - OR: sel=a, d0=b, d1=1.
  - NOT: sel=a, d0=1, d1=0.
  - NAND: sel=a, d0=1, d1=nb.
  - NOR: sel=a, d0=nb, d1=0.
  - XOR: sel=a, d0=b, d1=nb.
  - XNOR: sel=a, d0=nb, d1=b.
- Each mux output feeds one output flop. Outputs update together on the same edge.
- Truth table, in the order (and, or, not, nand, nor, xor, xnor):
  - a=0, b=0: 0,0,1,1,1,0,1
  - a=0, b=1: 0,1,1,1,0,1,0
  - a=1, b=0: 0,1,0,1,0,1,0
  - a=1, b=1: 1,1,0,0,0,0,1
- Invariants that must hold in every non-reset cycle:
  - `y_nand` = ~`y_and`
  - `y_nor` = ~`y_or`
  - `y_xnor` = ~`y_xor`

## Timing
- Latency is one cycle. Values of `a` and `b` sampled at edge N appear on the outputs after edge N and hold until edge N+1.
- Throughput is one new operand pair per cycle. There is no handshake and no enable.
- Reset: on any edge where `rst_n` = 0, all seven outputs are cleared to 0, whatever `a` and `b` are. This includes `y_not`, `y_nand` and `y_xnor`. Reset has priority over data.
- First valid result follows the first edge with `rst_n` = 1.
- Reset asserted mid-stream: outputs are 0 on the following edge, and the pipeline has no memory beyond one cycle.
- Input changes between edges must not affect the outputs until the next rising edge. X on `a` or `b` is not required to be handled.

## Structure
- There is no shared package; the block has no typedefs or constants beyond the 1'b0 and 1'b1 literals.
- One sub-module, `mux2`, with ports `d0`, `d1`, `sel` and `y`, all 1 bit. It is purely combinational and is instantiated 8 times: `nb` plus the seven gate functions.
- The top level contains the mux instances, the seven output flops with synchronous reset, and nothing else.

## Test plan
- Reset: drive `rst_n` = 0 for 2 edges with a=1, b=1, then check all seven outputs = 0.
- Exhaustive sweep: release reset and apply (a,b) = 00, 01, 10, 11, one pair per cycle. After each edge, check the truth-table row for the pair sampled on that edge, e.g. 11 → and=1, or=1, not=0, nand=0, nor=0, xor=0, xnor=1.
- Latency: change a from 0 to 1 with b=0 mid-cycle. Check `y_not` stays 1 until the next rising edge, then reads 0.
- Mid-stream reset: with a=0, b=0 (so nand, nor and xnor read 1), assert `rst_n` = 0 for one edge. Check all outputs = 0, then the row for 00 returns on the first edge after release.
- Complement invariants: run 64 random (a,b) pairs. Check nand = ~and, nor = ~or and xnor = ~xor on every cycle, and every output against a reference model delayed by one cycle.
